// File: rtl/tensor_warp_scheduler.sv
// Multi-warp WGMMA commit scheduler: per-warp metadata FIFOs and a round-robin
// grant, with a fixed burst of commit beats for each granted operation.

module tensor_warp_scheduler_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         empty,
    output logic         full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

module tensor_warp_scheduler #(
    parameter int NUM_WARPS = 4,
    parameter int DEPTH     = 4,
    parameter int BEATS     = 4,
    parameter int META_W    = 64,
    parameter int RD_W      = 6,
    parameter int IREG_BASE = 32,
    localparam int WID_W    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int BEAT_W   = $clog2(BEATS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WID_W-1:0]  in_wid,
    input  logic [META_W-1:0] in_meta,
    input  logic [RD_W-1:0]   in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WID_W-1:0]  out_wid,
    output logic [META_W-1:0] out_meta,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_sop,
    output logic              out_eop,
    output logic              busy
);
    localparam logic [BEAT_W-1:0] LAST = BEAT_W'(BEATS - 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                              state_q, state_d;
    logic [BEAT_W-1:0]                   beat_q, beat_d;
    logic [WID_W-1:0]                    rr_ptr_q, rr_ptr_d, grant_wid_q, grant_wid_d;
    logic [NUM_WARPS-1:0]                empty, full, push_w, pop_w;
    logic [NUM_WARPS-1:0][META_W-1:0]    head_meta;
    logic [NUM_WARPS-1:0][RD_W-1:0]      head_rd;
    logic                                run, pop_fire, found;
    logic [WID_W-1:0]                    sel;

    assign run      = (state_q == S_RUN);
    assign pop_fire = run && out_ready && (beat_q == LAST);
    // No bypass: a full queue refuses even if its head pops this cycle.
    assign in_ready = (int'(in_wid) < NUM_WARPS) ? !full[in_wid] : 1'b0;

    for (genvar i = 0; i < NUM_WARPS; i++) begin : g_warp
        assign push_w[i] = in_valid && in_ready && (in_wid == WID_W'(i));
        assign pop_w[i]  = pop_fire && (grant_wid_q == WID_W'(i));
        tensor_warp_scheduler_fifo #(.DEPTH(DEPTH), .W(META_W + RD_W)) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (push_w[i]),
            .pop   (pop_w[i]),
            .wdata ({in_meta, in_rd}),
            .rdata ({head_meta[i], head_rd[i]}),
            .empty (empty[i]),
            .full  (full[i])
        );
    end

    // Round-robin search starts one past the last granted warp.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        sel   = '0;
        for (int i = 1; i <= NUM_WARPS; i++) begin
            idx = (int'(rr_ptr_q) + i) % NUM_WARPS;
            if (!found && !empty[idx]) begin
                found = 1'b1;
                sel   = WID_W'(idx);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        rr_ptr_d    = rr_ptr_q;
        grant_wid_d = grant_wid_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_wid_d = sel;
                    rr_ptr_d    = sel;
                    beat_d      = '0;
                    state_d     = S_RUN;
                end
            end
            S_RUN: begin
                if (out_ready) begin
                    if (beat_q == LAST) begin
                        beat_d  = '0;
                        state_d = S_IDLE;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            beat_q      <= '0;
            rr_ptr_q    <= WID_W'(NUM_WARPS - 1);
            grant_wid_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_wid_q <= grant_wid_d;
        end
    end

    // Outputs derive only from state, so reset clears them without a clock.
    assign out_valid = run;
    assign out_sop   = run && (beat_q == '0);
    assign out_eop   = run && (beat_q == LAST);
    assign out_wid   = run ? grant_wid_q : '0;
    assign out_meta  = run ? head_meta[grant_wid_q] : '0;
    assign out_rd    = !run    ? '0 :
                       out_eop ? head_rd[grant_wid_q] :
                                 RD_W'(IREG_BASE + int'(beat_q));
    assign busy      = run || (|(~empty));
endmodule

// File: tb/tb_tensor_warp_scheduler.sv
// Bench for tensor_warp_scheduler: queue-level reference model checked every
// cycle, plus directed scenarios with literal expectations.

module tb_tensor_warp_scheduler;
    localparam int NW = 4, DEPTH = 4, BEATS = 4;

    logic        clk = 1'b0, reset = 1'b1;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic [1:0]  in_wid = '0, out_wid;
    logic [63:0] in_meta = '0, out_meta;
    logic [5:0]  in_rd = '0, out_rd;
    logic        out_sop, out_eop, busy;

    int nchecks = 0, nerr = 0;
    int sop_log[$];

    typedef struct packed {
        logic [63:0] meta;
        logic [5:0]  rd;
    } ent_t;

    ent_t mq[NW][$];
    bit   m_run;
    int   m_gw, m_beat, m_rr;

    tensor_warp_scheduler dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_wid(in_wid),
        .in_meta(in_meta), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_wid(out_wid),
        .out_meta(out_meta), .out_rd(out_rd),
        .out_sop(out_sop), .out_eop(out_eop), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int w = 0; w < NW; w++) mq[w].delete();
        m_run = 0; m_beat = 0; m_gw = 0; m_rr = NW - 1;
    endtask

    // One clock of the scheduler as the rules describe it, on queue contents.
    task automatic model_step();
        bit   acc, got;
        int   g, w;
        ent_t e;
        w   = int'(in_wid);
        acc = in_valid && (mq[w].size() < DEPTH);
        if (m_run) begin
            if (out_ready) begin
                if (m_beat == BEATS - 1) begin
                    void'(mq[m_gw].pop_front());
                    m_run = 0; m_beat = 0;
                end else m_beat++;
            end
        end else begin
            got = 0;
            for (int i = 1; i <= NW; i++) begin
                g = (m_rr + i) % NW;
                if (!got && mq[g].size() > 0) begin
                    got = 1; m_gw = g; m_rr = g; m_run = 1; m_beat = 0;
                end
            end
        end
        if (acc) begin
            e.meta = in_meta; e.rd = in_rd;
            mq[w].push_back(e);
        end
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_clear();
            else model_step();
        end
    end

    // Compare the DUT with the model every cycle.
    initial begin
        bit   e_busy;
        ent_t h;
        forever begin
            @(negedge clk);
            e_busy = m_run;
            for (int w = 0; w < NW; w++) if (mq[w].size() > 0) e_busy = 1;
            chk("busy", busy, e_busy);
            chk("in_ready", in_ready, mq[int'(in_wid)].size() < DEPTH);
            chk("out_valid", out_valid, m_run);
            if (m_run && mq[m_gw].size() > 0) begin
                h = mq[m_gw][0];
                chk("out_wid", out_wid, m_gw);
                chk("out_meta", out_meta, h.meta);
                chk("out_sop", out_sop, m_beat == 0);
                chk("out_eop", out_eop, m_beat == BEATS - 1);
                chk("out_rd", out_rd, (m_beat == BEATS - 1) ? h.rd : 6'((32 + m_beat) % 64));
                if (out_valid && out_sop && out_ready) sop_log.push_back(int'(out_wid));
            end else begin
                chk("idle_sop", out_sop, 0);
                chk("idle_eop", out_eop, 0);
                chk("idle_rd", out_rd, 0);
                chk("idle_meta", out_meta, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic push(input int w, input logic [63:0] m, input logic [5:0] r);
        in_valid = 1'b1; in_wid = 2'(w); in_meta = m; in_rd = r;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        out_ready = 1'b1;
        while (busy && n < 200) begin tick(); n++; end
        chk(nm, busy, 0);
    endtask

    initial begin
        int n;
        int exp_order[4] = '{3, 0, 2, 3};
        // Reset state
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_rd", out_rd, 0);
        tick(); tick();
        reset = 1'b0;
        tick();

        // Single request: beats in cycles 2..5
        push(0, 64'hA000_0000_0000_0005, 6'd5);
        chk("single_c1_valid", out_valid, 0);
        chk("single_c1_busy", busy, 1);
        tick();
        chk("single_c2_valid", out_valid, 1);
        chk("single_c2_rd", out_rd, 32);
        chk("single_c2_sop", out_sop, 1);
        chk("single_c2_eop", out_eop, 0);
        tick();
        chk("single_c3_rd", out_rd, 33);
        chk("single_c3_sop", out_sop, 0);
        tick();
        chk("single_c4_rd", out_rd, 34);
        tick();
        chk("single_c5_rd", out_rd, 5);
        chk("single_c5_eop", out_eop, 1);
        chk("single_c5_sop", out_sop, 0);
        chk("single_c5_meta", out_meta, 64'hA000_0000_0000_0005);
        tick();
        chk("single_c6_valid", out_valid, 0);
        chk("single_c6_busy", busy, 0);

        // Round-robin: warp 3 burst held while 2, 0, 3 queue up
        reset = 1'b1; tick(); reset = 1'b0; tick();
        sop_log.delete();
        out_ready = 1'b0;
        push(3, 64'h3333_0000_0000_0001, 6'd1);
        push(2, 64'h2222_0000_0000_0002, 6'd2);
        push(0, 64'h0000_0000_0000_0003, 6'd3);
        push(3, 64'h3333_0000_0000_0004, 6'd4);
        drain("rr_drain");
        chk("rr_count", sop_log.size(), 4);
        if (sop_log.size() == 4)
            for (int i = 0; i < 4; i++) chk("rr_order", sop_log[i], exp_order[i]);

        // Backpressure at beat 1
        push(1, 64'hB000_0000_0000_0009, 6'd9);
        tick();
        chk("bp_sop", out_sop, 1);
        tick();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("bp_hold_rd", out_rd, 33);
            chk("bp_hold_sop", out_sop, 0);
            chk("bp_hold_eop", out_eop, 0);
            tick();
        end
        chk("bp_hold_rd_end", out_rd, 33);
        out_ready = 1'b1;
        tick();
        chk("bp_resume_rd", out_rd, 34);
        tick();
        chk("bp_last_rd", out_rd, 9);
        chk("bp_last_eop", out_eop, 1);
        tick();
        chk("bp_done", out_valid, 0);

        // Full queue on warp 1
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) push(1, 64'hC100 + 64'(k), 6'(10 + k));
        in_wid = 2'd1;
        #1 chk("full_w1_ready", in_ready, 0);
        in_wid = 2'd2;
        #1 chk("full_w2_ready", in_ready, 1);
        push(2, 64'hC200_0000_0000_0003, 6'd3);
        in_wid = 2'd1;
        out_ready = 1'b1;
        n = 0;
        while (!(out_valid && out_eop) && n < 20) begin tick(); n++; end
        chk("full_eop_seen", out_valid && out_eop, 1);
        chk("full_eop_wid", out_wid, 1);
        chk("full_before_pop", in_ready, 0);
        tick();
        chk("full_after_pop", in_ready, 1);
        drain("full_drain");

        // Push/pop collision on warp 0
        push(0, 64'hD000_0000_0000_0007, 6'd7);
        n = 0;
        while (!(out_valid && out_eop) && n < 20) begin tick(); n++; end
        chk("col_eop_seen", out_eop, 1);
        in_valid = 1'b1; in_wid = 2'd0; in_meta = 64'hE000_0000_0000_000B; in_rd = 6'd11;
        #1 chk("col_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("col_idle", out_valid, 0);
        chk("col_busy", busy, 1);
        tick();
        chk("col_sop", out_sop, 1);
        chk("col_meta", out_meta, 64'hE000_0000_0000_000B);
        chk("col_wid", out_wid, 0);
        drain("col_drain");

        // Async reset at beat 2
        push(2, 64'hF200_0000_0000_0002, 6'd2);
        push(1, 64'hF100_0000_0000_0001, 6'd1);
        n = 0;
        while (!(out_valid && out_rd == 6'd34) && n < 20) begin tick(); n++; end
        chk("ar_beat2", out_rd, 34);
        #2 reset = 1'b1;
        #1;
        chk("ar_valid_async", out_valid, 0);
        chk("ar_busy_async", busy, 0);
        chk("ar_sop_async", out_sop, 0);
        tick();
        reset = 1'b0;
        chk("ar_busy_after", busy, 0);
        chk("ar_ready_after", in_ready, 1);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("ar_no_beat", out_valid, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end
endmodule

// File: doc/tensor_warp_scheduler.md
# tensor_warp_scheduler

Multi-warp issue scheduler for the tensor core's commit path. It accepts WGMMA execute requests from any warp, buffers their commit metadata in per-warp queues, and arbitrates round-robin among warps with pending work. For each granted operation it sequences a fixed burst of commit beats toward the commit interface. It sits between the dispatch-side execute handshake and the tensor core's commit handshake, and replaces the current single-warp-0 commit sequencing.

## Interface
Parameters:
- NUM_WARPS, 4, number of warps; WID_W = max(1, clog2(NUM_WARPS)).
- DEPTH, 4, entries per per-warp metadata queue (power of two, ≥2).
- BEATS, 4, commit beats per operation (≥2); BEAT_W = clog2(BEATS).
- META_W, 64, opaque metadata width (uuid, tmask, PC, wb packed by the caller).
- RD_W, 6, destination register index width.
- IREG_BASE, 32, register index of the first intermediate accumulator register.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  execute request valid.
- in_ready  out  1  request accepted when high with in_valid.
- in_wid  in  WID_W  issuing warp.
- in_meta  in  META_W  opaque metadata.
- in_rd  in  RD_W  final destination register.
- out_valid  out  1  commit beat valid.
- out_ready  in  1  commit stage accepts beat.
- out_wid  out  WID_W  warp of current beat.
- out_meta  out  META_W  metadata of current operation.
- out_rd  out  RD_W  register written by this beat.
- out_sop  out  1  first beat of the operation.
- out_eop  out  1  last beat of the operation.
- busy  out  1  any queue non-empty or a burst in progress.

## Operation
- Per-warp FIFO i stores {in_meta, in_rd}. It pushes on in_valid && in_ready && in_wid==i.
- in_ready = !full[in_wid]. This is a combinational path from in_wid. A full warp never blocks other warps. There is no bypass into a full queue, even when a pop happens in the same cycle.
- FSM states:
  - IDLE: out_valid=0. If any queue is non-empty, grant the first non-empty warp searching upward (modulo NUM_WARPS) from rr_ptr+1. On grant, latch grant_wid, set rr_ptr=grant_wid, set beat=0, and go to RUN. Otherwise stay in IDLE.
  - RUN: out_valid=1, and out_wid/out_meta come from the head of queue grant_wid.
    - out_sop = (beat==0).
    - out_eop = (beat==BEATS-1).
    - out_rd = head rd when out_eop; otherwise RD_W'(IREG_BASE + beat), truncated modulo 2^RD_W.
  - On out_valid && out_ready without eop: beat increments.
  - On out_valid && out_ready with eop: pop queue grant_wid, clear beat, and go to IDLE.
- A stalled beat (out_ready=0) holds every out_* signal stable.
- A push into the granted warp's queue during RUN does not disturb the current head. If a push and a pop hit the same queue in the same cycle, occupancy is unchanged.
- busy = (state==RUN) || any queue non-empty.
- Reset values: all queues empty, state IDLE, beat 0, rr_ptr = NUM_WARPS-1 (so warp 0 wins first), grant_wid 0. Outputs: out_valid 0, out_sop 0, out_eop 0, busy 0, out_rd/out_wid/out_meta 0. in_ready is 1 during and after reset.
- Reset asserted mid-burst: out_valid drops immediately (asynchronously). All pending operations are discarded and no partial burst resumes.

## Timing
- The push edge is cycle 0. The queue is non-empty in cycle 1 and the IDLE grant takes effect at the end of cycle 1. The first beat (sop) is valid in cycle 2. This is a minimum latency of 2 cycles.
- With out_ready held high, one operation occupies BEATS consecutive RUN cycles plus one IDLE arbitration cycle. Sustained throughput is one operation per BEATS+1 cycles.
- Arbitration happens only in IDLE. The grant is fixed for the whole burst; beats of different operations never interleave.
- The round-robin order guarantees that each non-empty warp is granted within NUM_WARPS operations.

## Test plan
- Single request: warp 0, rd=5, out_ready=1 → out_valid in cycles 2..5 with out_rd 32, 33, 34, 5; sop only in cycle 2; eop only in cycle 5; busy low from cycle 6.
- Round-robin: warps 2, 0 and 3 enqueue in the same-cycle window → grant order 0, 2, 3; each burst is 4 beats with one idle cycle between bursts; out_meta matches each warp's input.
- Backpressure: out_ready=0 for 3 cycles at beat 1 → out_rd holds 33 and sop/eop hold 0/0; the burst resumes at beat 1 with no beat lost or duplicated.
- Full queue: 4 pushes to warp 1 with out_ready=0 → in_ready low for in_wid=1, high for in_wid=2; the warp-2 push is accepted; after warp 1's eop fires, in_ready for warp 1 rises the next cycle.
- Push/pop collision: push to warp 0 in the same cycle as warp 0's eop fire → occupancy unchanged, and the next burst starts after one IDLE cycle carrying the new metadata.
- Async reset at beat 2 → out_valid is 0 before the next clock edge; after release busy=0 and in_ready=1, and no beat is emitted without a new request.
